// File: rtl/serial_pkg.sv
// serial_pkg
//   Definitions shared by the bit-serial add/subtract datapaths. It holds the
//   default operand width and the control FSM state encoding.
package serial_pkg;

  // Default operand width. The serial adder uses the same value.
  localparam int SERIAL_WIDTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } serial_state_e;

endpackage

// File: rtl/dffborrow.sv
// dffborrow
//   Single-bit flop with load enable and asynchronous clear. It holds the
//   borrow that is carried between the bit steps of the serial subtractor.
// Ports:
//   clk  - clock, rising edge
//   clr  - asynchronous clear, active high
//   load - when high, q takes d on the next clock edge
//   d    - next borrow value
//   q    - stored borrow
module dffborrow (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      q <= 1'b0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor. It computes diff = a - b one bit
//   per clock, LSB first. Operands are captured in parallel on an accepted
//   start. A single borrow flop carries the borrow between bit steps.
//
//   state | meaning
//   IDLE  | waiting for start; diff/borrow_out hold the last result
//   SHIFT | one bit step per cycle, WIDTH steps in total
//   DONE  | one-cycle done pulse; result stable
//
// Ports:
//   clk        - clock, rising edge
//   clr        - asynchronous reset, active high
//   start      - operation request, sampled only in IDLE
//   a, b       - minuend and subtrahend, captured on the accepted start
//   diff       - result (a - b) mod 2^WIDTH
//   borrow_out - final borrow, 1 when a < b (unsigned)
//   busy       - high in SHIFT and DONE
//   done       - single-cycle completion pulse
module serial_subtractor
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  serial_state_e    state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [CW-1:0]    cnt;
  logic             bor;
  logic             bor_next;
  logic             dbit;
  logic             accept;
  logic             bor_load;
  logic             bor_d;

  assign accept   = (state == S_IDLE) && start;
  assign dbit     = ra[0] ^ rb[0] ^ bor;
  assign bor_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & bor);

  // The borrow is cleared through its load path on capture. This avoids a
  // second, synchronous clear input on the flop.
  assign bor_load = accept || (state == S_SHIFT);
  assign bor_d    = accept ? 1'b0 : bor_next;

  dffborrow u_borrow (
    .clk  (clk),
    .clr  (clr),
    .load (bor_load),
    .d    (bor_d),
    .q    (bor)
  );

  // During SHIFT this output shows the running borrow. It becomes the final
  // borrow once the last bit step has completed.
  assign borrow_out = bor;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      ra    <= '0;
      rb    <= '0;
      cnt   <= '0;
      diff  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            cnt   <= '0;
            diff  <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          ra   <= ra >> 1;
          rb   <= rb >> 1;
          diff <= {dbit, diff[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk;
  logic       clr;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] diff;
  logic       borrow_out;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .a          (a),
    .b          (b),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [3:0] exp_diff;
    logic       exp_bor;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One full operation from IDLE. Samples are taken on falling edges.
  // Negedge count 1 is the cycle after the capture edge E0, so done is
  // expected at count WIDTH+1 = 5, which is the cycle between E4 and E5.
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb,
                       input logic [3:0] ed, input logic eb, input string nm);
    int  cyc;
    int  busy_cnt;
    int  lat;
    bit  got;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    cyc = 0; busy_cnt = 0; got = 0; lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) begin
        got = 1;
        lat = cyc;
        chk({nm, "_diff"}, 32'(diff), 32'(ed));
        chk({nm, "_borrow"}, 32'(borrow_out), 32'(eb));
      end
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'd5);
    chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
    @(negedge clk);
    chk({nm, "_done_pulse_width"}, 32'(done), 32'd0);
    chk({nm, "_busy_fall"}, 32'(busy), 32'd0);
    chk({nm, "_diff_hold"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int last_done;
    int gap_bad;
    logic [3:0] cap_diff;
    logic       cap_bor;

    vecs[0] = '{4'd11, 4'd6,  4'b0101, 1'b0};
    vecs[1] = '{4'd6,  4'd11, 4'b1011, 1'b1};
    vecs[2] = '{4'd15, 4'd15, 4'b0000, 1'b0};
    vecs[3] = '{4'd0,  4'd0,  4'b0000, 1'b0};
    vecs[4] = '{4'd0,  4'd1,  4'b1111, 1'b1};
    vecs[5] = '{4'd3,  4'd12, 4'b0111, 1'b1};

    start = 1'b0; a = 4'd0; b = 4'd0;
    clr = 1'b1;
    #12;
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_borrow", 32'(borrow_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < 6; i++)
      do_op(vecs[i].va, vecs[i].vb, vecs[i].exp_diff, vecs[i].exp_bor,
            $sformatf("vec%0d", i));

    // Start pulses during SHIFT and DONE must be ignored.
    @(negedge clk);
    a = 4'd9; b = 4'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_done = 0; cap_diff = 4'd0; cap_bor = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        cap_diff = diff;
        cap_bor = borrow_out;
      end
      if (i == 2) begin
        start = 1'b1; a = 4'd1; b = 4'd2;
      end else if (i == 3) begin
        start = 1'b0;
      end else if (i == 5) begin
        start = 1'b1; a = 4'd1; b = 4'd2;
      end else if (i == 6) begin
        start = 1'b0;
      end
    end
    chk("ignore_done_count", 32'(n_done), 32'd1);
    chk("ignore_diff", 32'(cap_diff), 32'd6);
    chk("ignore_borrow", 32'(cap_bor), 32'd0);
    chk("ignore_idle_busy", 32'(busy), 32'd0);
    chk("ignore_diff_hold", 32'(diff), 32'd6);

    // Asynchronous clear after two bit steps.
    @(negedge clk);
    a = 4'd12; b = 4'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    chk("clr_diff", 32'(diff), 32'd0);
    chk("clr_borrow", 32'(borrow_out), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    #2;
    clr = 1'b0;
    n_done = 0;
    gap_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) gap_bad++;
    end
    chk("clr_no_done", 32'(n_done), 32'd0);
    chk("clr_stays_idle", 32'(gap_bad), 32'd0);
    do_op(4'd12, 4'd5, 4'b0111, 1'b0, "after_clr");

    // start held high continuously, so an operation re-triggers every 6 cycles.
    @(negedge clk);
    a = 4'd7; b = 4'd2; start = 1'b1;
    n_done = 0; last_done = -1; gap_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        chk("hold_diff", 32'(diff), 32'd5);
        chk("hold_borrow", 32'(borrow_out), 32'd0);
        if (last_done >= 0 && (i - last_done) != 6) gap_bad++;
        last_done = i;
        n_done++;
      end
    end
    start = 1'b0;
    chk("hold_done_count", 32'(n_done), 32'd5);
    chk("hold_period", 32'(gap_bad), 32'd0);
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
